// File: rtl/line_window_gen_3x3.sv
// Streaming 3x3 window generator: two line buffers feed a 3x3 shift array, fully-interior windows only.
// Optional build macro LWG_SOF_EN adds the in_sof resync input.
module line_window_gen_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pix,
`ifdef LWG_SOF_EN
  input  logic              in_sof,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] p1,
  output logic [DATA_W-1:0] p2,
  output logic [DATA_W-1:0] p3,
  output logic [DATA_W-1:0] p4,
  output logic [DATA_W-1:0] p5,
  output logic [DATA_W-1:0] p6,
  output logic [DATA_W-1:0] p7,
  output logic [DATA_W-1:0] p8,
  output logic [DATA_W-1:0] p9,
  output logic              out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col, cur_col, nxt_col;
  logic [RW-1:0] row, cur_row, nxt_row;
  logic          accept, sof_hit, col_end, row_end, win_ok;
  logic [DATA_W-1:0] top_rd, mid_rd;

  // lb_mid holds the previous line, lb_top the line before it; neither is reset
  logic [DATA_W-1:0] lb_top [IMG_W];
  logic [DATA_W-1:0] lb_mid [IMG_W];
  logic [DATA_W-1:0] win [3][3];

  assign in_ready = ~rst & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

`ifdef LWG_SOF_EN
  assign sof_hit = in_sof;
`else
  assign sof_hit = 1'b0;
`endif

  always_comb begin
    cur_col = sof_hit ? '0 : col;
    cur_row = sof_hit ? '0 : row;
    col_end = (cur_col == COL_LAST);
    row_end = (cur_row == ROW_LAST);
    nxt_col = col_end ? '0 : cur_col + CW'(1);
    nxt_row = cur_row;
    if (col_end) nxt_row = row_end ? '0 : cur_row + RW'(1);
    win_ok  = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  end

  assign top_rd = lb_top[cur_col];
  assign mid_rd = lb_mid[cur_col];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[cur_col] <= mid_rd;
      lb_mid[cur_col] <= in_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= top_rd;
      win[1][2] <= mid_rd;
      win[2][2] <= in_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept) begin
      col       <= nxt_col;
      row       <= nxt_row;
      out_valid <= win_ok;
      out_last  <= win_ok & col_end & row_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  assign p1 = win[0][0];
  assign p2 = win[0][1];
  assign p3 = win[0][2];
  assign p4 = win[1][0];
  assign p5 = win[1][1];
  assign p6 = win[1][2];
  assign p7 = win[2][0];
  assign p8 = win[2][1];
  assign p9 = win[2][2];

endmodule

// File: tb/tb_line_window_gen_3x3.sv
// Bench for line_window_gen_3x3: a 4x4 and a 7x5 instance checked against an image-array reference model.
module tb_line_window_gen_3x3;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_pix = '0;
  logic       out_ready = 1'b0;
  logic       in_sof = 1'b0;
  logic       sel = 1'b0;

  logic a_in_ready, a_out_valid, a_out_last;
  logic b_in_ready, b_out_valid, b_out_last;
  logic [7:0] a_p1, a_p2, a_p3, a_p4, a_p5, a_p6, a_p7, a_p8, a_p9;
  logic [7:0] b_p1, b_p2, b_p3, b_p4, b_p5, b_p6, b_p7, b_p8, b_p9;
  logic a_in_valid, b_in_valid;

  assign a_in_valid = in_valid & ~sel;
  assign b_in_valid = in_valid & sel;

  always #5 clk = ~clk;

  line_window_gen_3x3 #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pix(in_pix),
`ifdef LWG_SOF_EN
    .in_sof(in_sof),
`endif
    .out_valid(a_out_valid), .out_ready(out_ready),
    .p1(a_p1), .p2(a_p2), .p3(a_p3), .p4(a_p4), .p5(a_p5), .p6(a_p6), .p7(a_p7), .p8(a_p8), .p9(a_p9),
    .out_last(a_out_last));

  line_window_gen_3x3 #(.DATA_W(8), .IMG_W(7), .IMG_H(5)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pix(in_pix),
`ifdef LWG_SOF_EN
    .in_sof(1'b0),
`endif
    .out_valid(b_out_valid), .out_ready(out_ready),
    .p1(b_p1), .p2(b_p2), .p3(b_p3), .p4(b_p4), .p5(b_p5), .p6(b_p6), .p7(b_p7), .p8(b_p8), .p9(b_p9),
    .out_last(b_out_last));

  logic [71:0] win_m;
  logic        valid_m, ready_m, last_m;
  assign win_m   = sel ? {b_p1, b_p2, b_p3, b_p4, b_p5, b_p6, b_p7, b_p8, b_p9}
                       : {a_p1, a_p2, a_p3, a_p4, a_p5, a_p6, a_p7, a_p8, a_p9};
  assign valid_m = sel ? b_out_valid : a_out_valid;
  assign ready_m = sel ? b_in_ready : a_in_ready;
  assign last_m  = sel ? b_out_last : a_out_last;

  int checks = 0;
  int failures = 0;

  // reference model: image array indexed by (row, col), expected windows in a queue
  int mw = 4, mh = 4;
  int mrow = 0, mcol = 0;
  logic [7:0]  img [0:7][0:7];
  logic [72:0] expq [$];
  logic [71:0] popped [$];
  logic        popped_last [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mrow = 0;
    mcol = 0;
    expq.delete();
    popped.delete();
    popped_last.delete();
  endtask

  task automatic cyc(input bit v, input logic [7:0] pix, input bit ordy, input bit sof, output bit acc);
    bit exp_rdy;
    logic [71:0] w;
    logic [72:0] e;
    in_valid  = v;
    in_pix    = pix;
    out_ready = ordy;
    in_sof    = sof;
    #1;
    exp_rdy = (expq.size() == 0) || ordy;
    chk("out_valid", 128'(valid_m), 128'(expq.size() != 0));
    chk("in_ready", 128'(ready_m), 128'(exp_rdy));
    if (expq.size() != 0 && ordy) begin
      e = expq.pop_front();
      chk("window", 128'(win_m), 128'(e[71:0]));
      chk("out_last", 128'(last_m), 128'(e[72]));
      popped.push_back(win_m);
      popped_last.push_back(last_m);
    end
    acc = v && exp_rdy;
    if (acc) begin
      if (sof) begin
        mrow = 0;
        mcol = 0;
      end
      img[mrow][mcol] = pix;
      if (mrow >= 2 && mcol >= 2) begin
        w = '0;
        for (int dr = -2; dr <= 0; dr++)
          for (int dc = -2; dc <= 0; dc++)
            w = {w[63:0], img[mrow+dr][mcol+dc]};
        expq.push_back({(mrow == mh-1 && mcol == mw-1), w});
      end
      mcol++;
      if (mcol == mw) begin
        mcol = 0;
        mrow = (mrow == mh-1) ? 0 : mrow + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input logic [7:0] pix, input bit sof, input int vpct, input int rpct);
    bit acc;
    int guard;
    guard = 0;
    acc = 0;
    while (!acc && guard < 200) begin
      cyc($urandom_range(0, 99) < vpct, pix, $urandom_range(0, 99) < rpct, sof, acc);
      guard++;
    end
    if (!acc) chk("px_timeout", 0, 1);
  endtask

  task automatic drain();
    bit acc;
    int guard;
    guard = 0;
    while (expq.size() != 0 && guard < 50) begin
      cyc(0, 8'h00, 1, 0, acc);
      guard++;
    end
    if (expq.size() != 0) chk("drain_timeout", 0, 1);
    cyc(0, 8'h00, 1, 0, acc);
  endtask

  task automatic frame16(input int vpct, input int rpct);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        send_px(8'(16*r + c), 0, vpct, rpct);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_sof = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(valid_m), 0);
    chk("rst_in_ready", 128'(ready_m), 0);
    chk("rst_out_last", 128'(last_m), 0);
    chk("rst_window", 128'(win_m), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  localparam logic [71:0] FIRST_WIN = 72'h00_01_02_10_11_12_20_21_22;

  initial begin
    logic [71:0] snap, tmp;
    bit acc;

    // test 1: one full-rate frame
    sel = 0; mw = 4; mh = 4;
    do_reset();
    frame16(100, 100);
    drain();
    chk("t1_count", 128'(popped.size()), 4);
    if (popped.size() == 4) begin
      chk("t1_first", 128'(popped[0]), 128'(FIRST_WIN));
      tmp = popped[3];
      chk("t1_last_p9", 128'(tmp[7:0]), 128'h33);
      chk("t1_last_flag", 128'(popped_last[3]), 1);
      chk("t1_first_flag", 128'(popped_last[0]), 0);
    end

    // test 2: downstream stall right after the first window
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3 + (r == 2 ? 0 : 1); c++)
        send_px(8'(16*r + c), 0, 100, 100);
    snap = win_m;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 8'h23, 0, 0, acc);
      chk("t2_stable", 128'(win_m), 128'(snap));
    end
    send_px(8'h23, 0, 100, 100);
    for (int r = 3; r < 4; r++)
      for (int c = 0; c < 4; c++)
        send_px(8'(16*r + c), 0, 100, 100);
    drain();
    chk("t2_count", 128'(popped.size()), 4);
    if (popped.size() >= 2) begin
      tmp = popped[1];
      chk("t2_second_p9", 128'(tmp[7:0]), 128'h23);
    end

    // test 3: two back-to-back frames
    do_reset();
    frame16(100, 100);
    frame16(100, 100);
    drain();
    chk("t3_count", 128'(popped.size()), 8);
    if (popped.size() == 8) begin
      tmp = popped[4];
      chk("t3_f2_p1", 128'(tmp[71:64]), 0);
      chk("t3_f2_first", 128'(popped[4]), 128'(FIRST_WIN));
    end

    // test 5: reset mid-frame, then restart
    do_reset();
    for (int k = 0; k < 9; k++)
      send_px(8'(16*(k/4) + (k%4)), 0, 100, 100);
    do_reset();
    frame16(100, 100);
    drain();
    chk("t5_count", 128'(popped.size()), 4);
    if (popped.size() == 4) chk("t5_first", 128'(popped[0]), 128'(FIRST_WIN));

`ifdef LWG_SOF_EN
    // test 6: partial frame then resync with in_sof
    do_reset();
    for (int k = 0; k < 6; k++)
      send_px(8'(16*(k/4) + (k%4)), 0, 100, 100);
    send_px(8'h00, 1, 100, 100);
    for (int k = 1; k < 16; k++)
      send_px(8'(16*(k/4) + (k%4)), 0, 100, 100);
    drain();
    chk("t6_count", 128'(popped.size()), 4);
    if (popped.size() == 4) begin
      chk("t6_first", 128'(popped[0]), 128'(FIRST_WIN));
      chk("t6_last_flag", 128'(popped_last[3]), 1);
    end
`endif

    // test 4: random gaps on both sides, 7x5 frames of random pixels
    sel = 1; mw = 7; mh = 5;
    do_reset();
    for (int f = 0; f < 200; f++)
      for (int k = 0; k < 35; k++)
        send_px(8'($urandom), 0, 70, 70);
    drain();
    chk("t4_count", 128'(popped.size()), 200 * 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
